// File: rtl/adc_conv_reader_pkg.sv
// Shared types and sizing helpers for the ADC conversion reader.
// State encoding, sample counter width and counter width functions.
`timescale 1ns/1ps
package adc_conv_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int SAMPLE_COUNT_W = 16;

    function automatic int wait_cnt_w(input int conv_wait);
        return (conv_wait > 1) ? $clog2(conv_wait) : 1;
    endfunction

    function automatic int bit_cnt_w(input int sample_bits);
        return (sample_bits > 1) ? $clog2(sample_bits) : 1;
    endfunction

endpackage

// File: rtl/adc_conv_reader_if.sv
// Trigger, serial ADC and sample-output bundle for adc_conv_reader.
// master = trigger/ADC side, slave = the reader itself.
`timescale 1ns/1ps
interface adc_conv_reader_if
    import adc_conv_reader_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int SAMPLE_BITS = 8
);
    logic                          start_conv;
    logic [N_CH-1:0]               adc_sdo;
    logic                          overrun_clr;
    logic                          adc_sck;
    logic                          adc_cs_n;
    logic [N_CH*SAMPLE_BITS-1:0]   sample_data;
    logic                          sample_valid;
    logic                          busy;
    logic                          overrun;
    logic [SAMPLE_COUNT_W-1:0]     sample_count;

    modport master (
        output start_conv, adc_sdo, overrun_clr,
        input  adc_sck, adc_cs_n, sample_data,
        input  sample_valid, busy, overrun, sample_count
    );

    modport slave (
        input  start_conv, adc_sdo, overrun_clr,
        output adc_sck, adc_cs_n, sample_data,
        output sample_valid, busy, overrun, sample_count
    );
endinterface

// File: rtl/adc_shift_lane.sv
// One serial ADC lane: MSB-first shift register for a single data line.
// Shifting is gated by the control FSM in adc_conv_reader.
`timescale 1ns/1ps
module adc_shift_lane #(
    parameter int SAMPLE_BITS = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   shift_en,
    input  logic                   sdo,
    output logic [SAMPLE_BITS-1:0] shreg
);
    logic [SAMPLE_BITS-1:0] r_shreg;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_shreg <= '0;
        end else if (shift_en) begin
            r_shreg <= {r_shreg[SAMPLE_BITS-2:0], sdo};
        end
    end

    assign shreg = r_shreg;
endmodule

// File: rtl/adc_conv_reader.sv
// Start-conversion responder: waits out the ADC conversion, then reads
// N_CH serial ADCs over a shared SCK/CS_N and strobes the assembled words.
`timescale 1ns/1ps
module adc_conv_reader
    import adc_conv_reader_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int SAMPLE_BITS = 8,
    parameter int CONV_WAIT   = 2
) (
    input  logic              internal_clk_40MHz,
    input  logic              reset_n,
    adc_conv_reader_if.slave  bus
);
    localparam int WCW = wait_cnt_w(CONV_WAIT);
    localparam int BCW = bit_cnt_w(SAMPLE_BITS);
    localparam int DW  = N_CH * SAMPLE_BITS;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(CONV_WAIT - 1);
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(SAMPLE_BITS - 1);

    state_t                    r_state;
    logic [WCW-1:0]            r_wait_cnt;
    logic [BCW-1:0]            r_bit_cnt;
    logic                      r_phase;
    logic                      r_sck;
    logic                      r_cs_n;
    logic                      r_valid;
    logic                      r_busy;
    logic                      r_overrun;
    logic [DW-1:0]             r_data;
    logic [SAMPLE_COUNT_W-1:0] r_sample_count;

    logic [DW-1:0]             w_shregs;
    logic                      w_shift_en;

    // Lanes sample on the SCK rising edge, when the ADC data is settled.
    assign w_shift_en = (r_state == SHIFT) && !r_phase;

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_lane
        adc_shift_lane #(
            .SAMPLE_BITS (SAMPLE_BITS)
        ) u_lane (
            .clk      (internal_clk_40MHz),
            .reset_n  (reset_n),
            .shift_en (w_shift_en),
            .sdo      (bus.adc_sdo[ch]),
            .shreg    (w_shregs[ch*SAMPLE_BITS +: SAMPLE_BITS])
        );
    end

    always_ff @(posedge internal_clk_40MHz) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_wait_cnt     <= '0;
            r_bit_cnt      <= '0;
            r_phase        <= 1'b0;
            r_sck          <= 1'b0;
            r_cs_n         <= 1'b1;
            r_valid        <= 1'b0;
            r_busy         <= 1'b0;
            r_overrun      <= 1'b0;
            r_data         <= '0;
            r_sample_count <= '0;
        end else begin
            // A strobe while busy is dropped; setting beats clearing.
            if (bus.start_conv && (r_state != IDLE)) begin
                r_overrun <= 1'b1;
            end else if (bus.overrun_clr) begin
                r_overrun <= 1'b0;
            end

            unique case (r_state)
                IDLE: begin
                    if (bus.start_conv) begin
                        r_state    <= CONV;
                        r_wait_cnt <= '0;
                        r_busy     <= 1'b1;
                    end
                end
                CONV: begin
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                    if (r_wait_cnt == WAIT_LAST) begin
                        r_state   <= SHIFT;
                        r_cs_n    <= 1'b0;
                        r_bit_cnt <= '0;
                        r_phase   <= 1'b0;
                    end
                end
                SHIFT: begin
                    r_phase <= ~r_phase;
                    if (!r_phase) begin
                        r_sck <= 1'b1;
                    end else begin
                        r_sck     <= 1'b0;
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == BIT_LAST) begin
                            r_state        <= DONE;
                            r_data         <= w_shregs;
                            r_valid        <= 1'b1;
                            r_cs_n         <= 1'b1;
                            r_sample_count <= r_sample_count + 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.adc_sck      = r_sck;
    assign bus.adc_cs_n     = r_cs_n;
    assign bus.sample_data  = r_data;
    assign bus.sample_valid = r_valid;
    assign bus.busy         = r_busy;
    assign bus.overrun      = r_overrun;
    assign bus.sample_count = r_sample_count;
endmodule

// File: doc/adc_conv_reader.md
Name: adc_conv_reader

Overview:
- Responder side of the ADC start-conversion strobe produced by the system clock block.
- On each one-cycle start_conv pulse it:
  - waits the ADC conversion time;
  - clocks N_CH serial ADCs in parallel over a shared SCK/CS_N;
  - assembles one word per channel;
  - presents all words with a one-cycle valid strobe.
- Sits between the clock/trigger block and the acquisition/DMA path, all in the 40 MHz domain.

Parameters:
- N_CH, 4, number of ADC channels; one serial data line each.
- SAMPLE_BITS, 8, bits per sample, MSB first; minimum 2.
- CONV_WAIT, 2, cycles from start acceptance to CS_N assertion; minimum 1.

Ports:
- internal_clk_40MHz  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous active-low reset.
- start_conv  in  1  one-cycle conversion strobe, already synchronous to internal_clk_40MHz.
- adc_sdo  in  N_CH  serial data from each ADC; valid while adc_sck is low.
- overrun_clr  in  1  clears the sticky overrun flag.
- adc_sck  out  1  serial clock to the ADCs.
- adc_cs_n  out  1  ADC chip select, active low.
- sample_data  out  N_CH*SAMPLE_BITS  channel ch occupies bits [ch*SAMPLE_BITS +: SAMPLE_BITS].
- sample_valid  out  1  one-cycle strobe; sample_data is new.
- busy  out  1  high in every state except IDLE.
- overrun  out  1  sticky; a start_conv arrived while busy.
- sample_count  out  16  completed samples; wraps 0xFFFF -> 0.

Behaviour:
- Reset:
  - Applies when reset_n is low at a clock edge, including mid-readout.
  - State IDLE.
  - adc_sck=0, adc_cs_n=1, sample_data=0, sample_valid=0, busy=0, overrun=0, sample_count=0.
  - Shift registers and counters are cleared.
- Every output is registered. The state sequence is IDLE -> CONV -> SHIFT -> DONE -> IDLE.
- IDLE:
  - start_conv=1 -> CONV with wait_cnt=0.
  - The edge that samples start_conv is E0.
- CONV:
  - wait_cnt increments each cycle.
  - At wait_cnt==CONV_WAIT-1 -> SHIFT, with adc_cs_n<=0, bit_cnt=0, phase=0.
- SHIFT: phase alternates on every edge.
  - phase 0: adc_sck<=1, and every lane shifts shreg[ch] <= {shreg[ch][SAMPLE_BITS-2:0], adc_sdo[ch]}.
  - phase 1: adc_sck<=0 and bit_cnt increments.
  - phase 1 with bit_cnt==SAMPLE_BITS-1 -> DONE.
  - At the same edge: sample_data<=all shregs, sample_valid<=1, adc_cs_n<=1, sample_count<=sample_count+1.
- DONE:
  - Lasts exactly one cycle, then IDLE.
  - sample_valid<=0 on leaving DONE.
- Latency: sample_valid is high in the cycle after edge E0+CONV_WAIT+2*SAMPLE_BITS (18 cycles for the defaults).
- busy:
  - Rises at E0; falls at the DONE->IDLE edge (busy time = CONV_WAIT+2*SAMPLE_BITS+1 = 19 cycles).
  - A 2 MHz strobe (period of 20 cycles) is therefore always accepted.
- start_conv while busy (CONV, SHIFT or DONE):
  - The strobe is ignored and the readout in progress is unaffected.
  - overrun<=1.
- Overrun flag:
  - overrun_clr clears it; if set and clear fall in the same cycle, set wins.
  - start_conv in IDLE never sets it.
- adc_sck is only toggled in SHIFT and is 0 whenever adc_cs_n=1.
- sample_data holds its value until the next completed sample.

Decomposition:
- Package adc_conv_reader_pkg holds:
  - the state enum {IDLE, CONV, SHIFT, DONE} (2-bit encoding);
  - the SAMPLE_COUNT_W=16 constant;
  - the counter-width functions (clog2 of CONV_WAIT and SAMPLE_BITS).
- Sub-module adc_shift_lane: one per channel, generated N_CH times.
  - Inputs: clk, reset_n, shift_en, sdo.
  - Output: its SAMPLE_BITS shift register.
  - The control FSM stays in the top level.

Test Plan:
- Single conversion with defaults:
  - Stimulus: ADC models return 0xA5, 0x3C, 0xFF, 0x01 MSB-first; pulse start_conv.
  - Required: sample_data=0x01FF3CA5 and sample_valid high for 1 cycle, 18 cycles after the start edge; exactly 8 adc_sck rising edges while adc_cs_n=0; sample_count=1.
- Periodic 20-cycle start_conv, 100 pulses:
  - Required: 100 valid strobes, overrun stays 0, sample_count=100, busy low exactly 1 cycle per period.
- start_conv during SHIFT:
  - Required: no extra readout, current sample unaffected, overrun=1.
  - Then overrun_clr with no coincident start -> overrun=0.
  - Then overrun_clr in the same cycle as a busy start -> overrun stays 1.
- reset_n low for one cycle mid-SHIFT:
  - Required: next cycle adc_cs_n=1, adc_sck=0, busy=0, sample_valid=0, sample_count=0.
  - A subsequent start gives a correct sample.
- sample_count preloaded to 0xFFFF by forcing, then one conversion -> sample_count=0x0000.
- Parameter sweep N_CH=1, SAMPLE_BITS=2, CONV_WAIT=1:
  - Stimulus: sdo pattern 1,0.
  - Required: sample_data=2'b10, valid 5 cycles after the start edge.
